// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter sharing one FIFO write port among NUM_REQ producers.
// The grant path is combinational; a multi-beat packet holds the port until its last beat.
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          busy,
    output logic [IDW-1:0]                owner,
    output logic [15:0]                   pkt_count
);

    typedef enum logic {ARB, LOCK} state_e;

    localparam logic [IDW:0]   NREQ     = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

    state_e                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        owner_q, owner_d;
    logic [15:0]           pkt_count_q, pkt_count_d;

    logic [DATA_WIDTH-1:0] beat [NUM_REQ];
    logic                  found;
    logic [IDW-1:0]        winner;
    logic [IDW-1:0]        sel;
    logic [IDW:0]          cand;
    logic                  grant_ok;
    logic                  accept;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_beat
        assign beat[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the far end back toward rr_ptr so the closest valid index wins last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= NREQ) cand = cand - NREQ;
            if (req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    // While locked, ready is offered to the owner even if it has no beat this cycle.
    always_comb begin
        sel       = (state_q == LOCK) ? owner_q : winner;
        grant_ok  = rst_n && !fifo_full && ((state_q == LOCK) || found);
        req_ready = '0;
        if (grant_ok) req_ready[sel] = 1'b1;
    end

    assign accept       = |(req_valid & req_ready);
    assign fifo_wr_en   = accept;
    assign fifo_wr_data = beat[sel];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        pkt_count_d = pkt_count_q;
        if (accept) begin
            owner_d = sel;
            if (req_last[sel]) begin
                state_d     = ARB;
                rr_ptr_d    = next_idx(sel);
                pkt_count_d = pkt_count_q + 16'd1;
            end else begin
                state_d = LOCK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign busy      = (state_q == LOCK);
    assign owner     = owner_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all checked every
// cycle against a round-robin/packet-lock reference model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            fifo_full, fifo_wr_en, busy;
    logic [DW-1:0]   fifo_wr_data;
    logic [1:0]      owner;
    logic [15:0]     pkt_count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] wlog[$];
    logic [DW-1:0] elog[$];

    // Reference model state
    bit           m_locked = 0;
    int           m_owner  = 0;
    int           m_rr     = 0;
    int           m_cnt    = 0;
    logic [N-1:0] m_acc    = '0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .busy(busy),
        .owner(owner), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, wlog.size(), elog.size());
        for (int i = 0; i < elog.size() && i < wlog.size(); i++)
            chk($sformatf("%s_w%0d", name, i), {24'b0, wlog[i]}, {24'b0, elog[i]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    // Single compare process: expected grant from the model, then advance the model.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int           g;
        int           idx;
        exp_ready = '0;
        g = -1;
        if (rst_n && !fifo_full) begin
            if (m_locked) exp_ready[m_owner] = 1'b1;
            else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (g < 0 && req_valid[idx]) begin
                        g = idx;
                        exp_ready[idx] = 1'b1;
                    end
                end
            end
        end
        m_acc = exp_ready & req_valid;
        if (m_locked && m_acc != '0) g = m_owner;
        chk("req_ready", {28'b0, req_ready}, {28'b0, exp_ready});
        chk("fifo_wr_en", {31'b0, fifo_wr_en}, {31'b0, |m_acc});
        if (|m_acc) chk("fifo_wr_data", {24'b0, fifo_wr_data}, {24'b0, req_data[g*DW +: DW]});
        chk("busy", {31'b0, busy}, {31'b0, m_locked});
        chk("owner", {30'b0, owner}, m_owner);
        chk("pkt_count", {16'b0, pkt_count}, m_cnt);
        if (fifo_wr_en === 1'b1) wlog.push_back(fifo_wr_data);
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
        end else if (|m_acc) begin
            m_owner = g;
            if (req_last[g]) begin
                m_locked = 0;
                m_rr     = (g + 1) % N;
                m_cnt    = (m_cnt + 1) & 16'hFFFF;
            end else begin
                m_locked = 1;
            end
        end
    end

    initial begin
        int rem [N];
        req_valid = '1; req_last = '0; req_data = '0; fifo_full = 1'b0;

        // Reset held with every requester valid
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", {28'b0, req_ready}, 32'd0);
            chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_owner", {30'b0, owner}, 32'd0);
            chk("rst_pkt", {16'b0, pkt_count}, 32'd0);
        end
        tick();

        // Round-robin over continuous single-beat packets
        rst_n = 1'b1;
        req_valid = '1; req_last = '1;
        for (int i = 0; i < N; i++) set_d(i, DW'(10 * i));
        wlog.delete();
        repeat (8) tick();
        req_valid = '0;
        chk("rr_pkt", {16'b0, pkt_count}, 32'd8);
        elog = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd0, 8'd10, 8'd20, 8'd30};
        chk_log("rr");

        // Packet lock: req1 after a req0 single beat moves the pointer to 1
        req_valid = 4'b0001; req_last = 4'b0001; set_d(0, 8'd0);
        tick();
        wlog.delete();
        req_valid = 4'b0111; req_last = 4'b0101; set_d(1, -8'sd5); set_d(2, 8'd20);
        tick();
        chk("lock_busy1", {31'b0, busy}, 32'd1);
        chk("lock_owner", {30'b0, owner}, 32'd1);
        set_d(1, -8'sd6);
        tick();
        chk("lock_busy2", {31'b0, busy}, 32'd1);
        set_d(1, -8'sd7); req_last[1] = 1'b1;
        tick();
        chk("lock_busy3", {31'b0, busy}, 32'd0);
        req_valid = 4'b0101;
        tick();
        chk("lock_next_owner", {30'b0, owner}, 32'd2);
        req_valid = '0;
        elog = '{8'hFB, 8'hFA, 8'hF9, 8'd20};
        chk_log("lock");

        // Backpressure mid-packet of req3
        wlog.delete();
        req_valid = 4'b1001; req_last = 4'b0001; set_d(0, 8'd77); set_d(3, 8'd1);
        tick();
        set_d(3, 8'd2);
        tick();
        set_d(3, 8'd3); fifo_full = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_wr_en", {31'b0, fifo_wr_en}, 32'd0);
            chk("bp_ready", {28'b0, req_ready}, 32'd0);
            chk("bp_busy", {31'b0, busy}, 32'd1);
            tick();
        end
        fifo_full = 1'b0;
        tick();
        set_d(3, 8'd4);
        tick();
        set_d(3, 8'd5); req_last[3] = 1'b1;
        tick();
        chk("bp_done_busy", {31'b0, busy}, 32'd0);
        req_valid = '0;
        elog = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        chk_log("bp");

        // Owner valid gap while req0 waits
        wlog.delete();
        req_valid = 4'b0100; req_last = 4'b0000; set_d(2, 8'd50);
        tick();
        set_d(2, 8'd51);
        tick();
        req_valid = 4'b0001; req_last = 4'b0001; set_d(0, 8'd9);
        repeat (5) begin
            @(negedge clk);
            chk("gap_wr_en", {31'b0, fifo_wr_en}, 32'd0);
            chk("gap_ready0", {31'b0, req_ready[0]}, 32'd0);
            tick();
        end
        req_valid = 4'b0101; req_last = 4'b0101; set_d(2, 8'd52);
        tick();
        chk("gap_busy", {31'b0, busy}, 32'd0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        elog = '{8'd50, 8'd51, 8'd52, 8'd9};
        chk_log("gap");

        // Random traffic: multi-beat packets, valid gaps between beats, full, rare resets
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !m_acc[i]) continue;
                if (req_valid[i] && m_acc[i]) rem[i]--;
                req_valid[i] = ($urandom_range(0, 9) < 7);
                if (req_valid[i]) begin
                    if (rem[i] <= 0) rem[i] = $urandom_range(1, 4);
                    req_last[i] = (rem[i] == 1);
                    set_d(i, DW'($urandom));
                end
            end
            fifo_full = ($urandom_range(0, 4) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            tick();
        end

        // Counter wrap, then reset while locked
        req_valid = '0; fifo_full = 1'b0; rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        req_valid = 4'b0010; req_last = 4'b0010; set_d(1, 8'h11);
        repeat (65535) tick();
        chk("wrap_ffff", {16'b0, pkt_count}, 32'h0000FFFF);
        tick();
        chk("wrap_zero", {16'b0, pkt_count}, 32'd0);
        req_last = '0;
        tick();
        chk("midlock_busy", {31'b0, busy}, 32'd1);
        chk("midlock_owner", {30'b0, owner}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rstlock_busy", {31'b0, busy}, 32'd0);
        chk("rstlock_owner", {30'b0, owner}, 32'd0);
        rst_n = 1'b1; req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin, packet-aware arbiter that shares one FIFO write port among NUM_REQ requesters. It sits between the producer blocks and the write side of a shared FIFO or LIFO instance. Once a packet starts, the arbiter locks to that requester until its last beat is accepted. Acceptance is gated by the buffer's full flag, so the arbiter never writes a full buffer.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16, power of two not required
- DATA_WIDTH, 8, beat width in bits; data is signed two's complement and passes through unmodified
- IDW, $clog2(NUM_REQ), width of requester index (derived, not overridable)

Ports (reset is synchronous and active-low; one clock):
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last-beat-of-packet flag, qualified by req_valid
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot-or-zero; beat accepted when req_valid[i] & req_ready[i]
- fifo_full  in  1  full flag from the shared buffer
- fifo_wr_en  out  1  write strobe to buffer
- fifo_wr_data  out  DATA_WIDTH  write data to buffer
- busy  out  1  high while locked mid-packet
- owner  out  IDW  index of the last granted requester (current lock owner while busy)
- pkt_count  out  16  count of completed packets, wraps 0xFFFF -> 0x0000

## Operation
- State registers: state {ARB, LOCK}, rr_ptr (IDW), owner (IDW), pkt_count (16).
- ARB:
  - winner = first i with req_valid[i], searched from rr_ptr upward with wrap at NUM_REQ-1 -> 0.
  - If a winner exists and ~fifo_full: req_ready[winner]=1, fifo_wr_en=1, fifo_wr_data=req_data[winner], owner<=winner.
    - If req_last[winner]: stay in ARB, rr_ptr<=next(winner), pkt_count++.
    - Otherwise: go to LOCK.
  - If there is no winner or fifo_full: no grant, all state holds.
- LOCK:
  - Only owner is serviced: req_ready[owner] = ~fifo_full, all others 0.
  - On an accepted beat: write as above. If req_last[owner]: state<=ARB, rr_ptr<=next(owner), pkt_count++.
  - owner dropping req_valid mid-packet: the lock holds indefinitely, no writes, and other requesters stay blocked.
- next(i) = (i==NUM_REQ-1) ? 0 : i+1.
- fifo_wr_en == |(req_valid & req_ready) every cycle; at most one bit of req_ready is high.
- A single-beat packet (valid & last together in ARB) never enters LOCK.
- Requester rules: req_data and req_last must hold stable while req_valid & ~req_ready. The arbiter does not check this.
- fifo_full is sampled the same cycle. The buffer must not assert full late relative to a write in that cycle.

## Timing
- Grant path is combinational: req_valid/req_last/fifo_full -> req_ready/fifo_wr_en/fifo_wr_data, zero latency.
- State, rr_ptr, owner, busy and pkt_count update on the rising edge following acceptance.
- busy = (state==LOCK), registered.
- Reset, synchronous, on any edge with rst_n=0:
  - state=ARB, rr_ptr=0, owner=0, pkt_count=0.
  - While rst_n=0, req_ready=0 and fifo_wr_en=0 combinationally; fifo_wr_data is don't-care.
- Reset mid-packet: the lock is abandoned and the FIFO keeps its partial packet (integrity is an upstream concern). After reset the first grant goes to the lowest-index valid requester.
- fifo_full rising while locked: stall with no write; the lock is kept and resumes on the first cycle full=0.
- Simultaneous requests with rr_ptr=k: the grant goes to k if valid, otherwise the next valid index cyclically.

## Test plan
- Reset: hold rst_n=0 for 3 clk with all req_valid=1 -> req_ready=0, fifo_wr_en=0, busy=0, owner=0, pkt_count=0 throughout.
- Round-robin fairness: NUM_REQ=4, all requesters send continuous single-beat packets (last=1), data=8'sd(10*i) -> write order 0,10,20,30,0,10,... ; pkt_count=8 after 8 cycles.
- Packet lock: req1 sends a 3-beat packet (-5,-6,-7, last on beat 3) while req0/req2 are valid -> writes -5,-6,-7 contiguous, busy=1 for 2 cycles, then the next grant goes to req2 (rr_ptr=2).
- Backpressure: fifo_full=1 for 4 cycles mid-packet of req3 -> fifo_wr_en=0 and req_ready=0 during those cycles, busy stays 1, the remaining beats are written after full drops, no beat lost or duplicated.
- Valid gap in lock: owner drops req_valid for 5 cycles mid-packet while req0 is valid -> no writes and req_ready[0]=0 for 5 cycles, the packet resumes when valid returns.
- Counter wrap and reset mid-lock: preload by sending 65535 packets, one more -> pkt_count=0x0000. Then assert rst_n=0 while busy=1 -> busy=0, owner=0 next edge.
